uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter byte port (tx_byte plus valid/ready) among NUM_REQ byte-stream requesters.
- Arbitration is round-robin with packet lock: the winner keeps the transmitter until its last byte or until MAX_BURST bytes, whichever comes first.
- Sits between on-chip message sources and the uart block's tx side; a one-byte output register decouples requesters from the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- MAX_BURST, 8, maximum bytes accepted per grant before forced rotation; must be at least 1.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_byte  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of requester i's packet.
- req_ready  out  NUM_REQ  byte accepted from requester i when req_valid[i] && req_ready[i].
- tx_valid  out  1  output register holds a byte for the transmitter.
- tx_byte  out  8  byte to the transmitter.
- tx_ready  in  1  transmitter can take a byte; transfer when tx_valid && tx_ready.
- grant_id  out  ID_W  index of the current or most recent grant holder.
- busy  out  1  high in GRANT state or while tx_valid is high.

Behaviour:
- Reset (asynchronous, any time, including mid-packet): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, tx_valid=0, tx_byte=0x00, req_ready=0, busy=0. Any byte held in the output register is dropped.
- FSM states: IDLE, GRANT.
- IDLE:
  - req_ready is all zeros.
  - If any req_valid bit is set, pick the first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: grant_id = winner, burst_cnt = 0, state = GRANT.
  - If no req_valid bit is set, stay in IDLE.
- GRANT:
  - req_ready[grant_id] = (!tx_valid || tx_ready); all other req_ready bits are 0. This is combinational from state and tx_valid/tx_ready.
  - Accept (req_valid[g] && req_ready[g]): tx_byte <= req_byte[g], tx_valid <= 1, burst_cnt += 1.
  - Release: on an accept where req_last[g]=1 or burst_cnt+1 == MAX_BURST, go to IDLE and set rr_ptr = (g+1) mod NUM_REQ. Both conditions together cause a single release.
  - If req_valid[g] is low, hold the grant and wait indefinitely; no timeout.
- Output register:
  - On tx_valid && tx_ready with no accept that cycle, tx_valid <= 0.
  - On tx_valid && tx_ready with an accept that cycle, the register reloads and tx_valid stays 1 (no bubble).
  - tx_byte stays stable while tx_valid && !tx_ready.
- Latency:
  - req_valid rises in IDLE at cycle n: grant at n+1, req_ready at n+1, tx_valid at n+2.
  - Sustained throughput of 1 byte/cycle if tx_ready stays high.
  - One IDLE bubble cycle between grants.
- busy = (state==GRANT) || tx_valid.
- grant_id holds its value through IDLE until the next grant.
- Requesters must hold req_byte/req_last stable while req_valid && !req_ready; the scheduler does not check this.

Test Plan:
- Single requester:
  - Stimulus: req 2 sends 0xA5, 0x5A (last on 0x5A), tx_ready=1.
  - Required: grant_id=2 one cycle after req_valid; tx_byte 0xA5 then 0x5A on consecutive cycles; IDLE after; rr_ptr=3.
- Round-robin:
  - Stimulus: all 4 requesters hold single-byte packets (req i sends 0x10+i, last=1), starting with rr_ptr=0.
  - Required: tx order 0x10, 0x11, 0x12, 0x13, then 0x10, with one bubble between grants.
- Burst limit:
  - Stimulus: MAX_BURST=8; req 1 streams 12 bytes 0x00..0x0B with last only on 0x0B; req 3 also valid.
  - Required: req 1 sends 0x00..0x07; req 3 is granted next; req 1 resumes at 0x08 on its next grant.
- Backpressure:
  - Stimulus: tx_ready=0 for 5 cycles after the first byte 0x3C.
  - Required: tx_valid=1 and tx_byte=0x3C stable; req_ready[g]=0 throughout; on tx_ready=1 the next byte loads in the same cycle.
- Simultaneous last and limit:
  - Stimulus: MAX_BURST=2; 2-byte packet with last on byte 2.
  - Required: exactly one release; next grant goes to the next requester in order.
- Reset mid-packet:
  - Stimulus: assert reset_n=0 asynchronously while tx_valid=1 in GRANT.
  - Required: tx_valid, req_ready and busy go to 0 immediately; after release, the first grant goes to the lowest valid index searching from 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter byte port among
// NUM_REQ byte-stream requesters, with packet lock and a burst limit.
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_byte,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grantId_q, grantId_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
  logic             txValid_q, txValid_d;
  logic [7:0]       txByte_q, txByte_d;

  logic [ID_W-1:0]  winnerId;
  logic             anyValid;
  int               searchIdx;
  logic             grantValid;
  logic             grantLast;
  logic [7:0]       grantByte;
  logic             grantReady;
  logic             accept;
  logic             limitHit;

  assign grantValid = req_valid[grantId_q];
  assign grantLast  = req_last[grantId_q];
  assign grantByte  = req_byte[{grantId_q, 3'b000} +: 8];
  assign grantReady = (state_q == GRANT) && (!txValid_q || tx_ready);
  assign accept     = grantReady && grantValid;
  assign limitHit   = (burstCnt_q == CNT_LAST);

  // Find the first valid requester starting at rrPtr_q; scanning downwards lets the closest one win.
  always_comb begin
    winnerId  = rrPtr_q;
    anyValid  = 1'b0;
    searchIdx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      searchIdx = (int'(rrPtr_q) + k) % NUM_REQ;
      if (req_valid[searchIdx]) begin
        winnerId = ID_W'(searchIdx);
        anyValid = 1'b1;
      end
    end
  end

  // Only the grant holder sees ready, and only when the output register can take a byte.
  always_comb begin
    req_ready = '0;
    if (grantReady) begin
      req_ready[grantId_q] = 1'b1;
    end
  end

  // Arbitration FSM: pick a winner in IDLE, stay locked in GRANT until last byte or burst limit.
  always_comb begin
    state_d    = state_q;
    grantId_d  = grantId_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          state_d    = GRANT;
          grantId_d  = winnerId;
          burstCnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burstCnt_d = burstCnt_q + 1'b1;
          if (grantLast || limitHit) begin
            state_d    = IDLE;
            burstCnt_d = '0;
            rrPtr_d    = (grantId_q == ID_W'(NUM_REQ - 1)) ? '0 : grantId_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-byte output register: reload on accept, empty when the transmitter drains it.
  always_comb begin
    txValid_d = txValid_q;
    txByte_d  = txByte_q;
    if (accept) begin
      txValid_d = 1'b1;
      txByte_d  = grantByte;
    end else if (txValid_q && tx_ready) begin
      txValid_d = 1'b0;
    end
  end

  // State registers; reset drops any byte held for the transmitter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grantId_q  <= '0;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
      txValid_q  <= 1'b0;
      txByte_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      grantId_q  <= grantId_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
      txValid_q  <= txValid_d;
      txByte_q   <= txByte_d;
    end
  end

  assign tx_valid = txValid_q;
  assign tx_byte  = txByte_q;
  assign grant_id = grantId_q;
  assign busy     = (state_q == GRANT) || txValid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model and a byte-order scoreboard.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int MAXB = 8;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_byte = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_byte;
  logic              tx_ready = 1'b0;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  int vectorCount = 0;
  int missCount   = 0;
  int cycCount    = 0;

  // Behavioural model: owner index (-1 when nobody holds the port), pointer, burst count, output register.
  int         mOwner, mGrant, mPtr, mCnt;
  bit         mTxValid;
  logic [7:0] mTxByte;

  logic [7:0] pktByte [NREQ][$];
  bit         pktLast [NREQ][$];
  logic [7:0] sbQ[$];
  logic [7:0] xferLog[$];
  int         xferCyc[$];
  logic [7:0] expLog[$];

  uart_tx_scheduler #(.NUM_REQ(NREQ), .MAX_BURST(MAXB), .ID_W(IDW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_byte (req_byte),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycCount);
    end
  endtask

  task automatic modelReset();
    mOwner = -1; mGrant = 0; mPtr = 0; mCnt = 0;
    mTxValid = 1'b0; mTxByte = 8'h00;
    sbQ.delete();
  endtask

  task automatic clearStimulus();
    for (int i = 0; i < NREQ; i++) begin
      pktByte[i].delete();
      pktLast[i].delete();
    end
    req_valid = '0; req_byte = '0; req_last = '0;
    xferLog.delete(); xferCyc.delete();
  endtask

  task automatic pushByte(input int r, input logic [7:0] b, input bit last);
    pktByte[r].push_back(b);
    pktLast[r].push_back(last);
  endtask

  task automatic genPacket(input int r);
    int len;
    len = $urandom_range(1, 12);
    for (int j = 0; j < len; j++) pushByte(r, 8'($urandom_range(255)), (j == len - 1));
  endtask

  // Present the next queued byte of each idle requester with probability pct percent.
  task automatic applyStimulus(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] && pktByte[i].size() > 0 && $urandom_range(99) < pct) begin
        req_valid[i]          = 1'b1;
        req_byte[i*8 +: 8]    = pktByte[i][0];
        req_last[i]           = pktLast[i][0];
      end
    end
  endtask

  // One clock: compare DUT with the model, advance the model, retire accepted bytes.
  task automatic cycle();
    bit              readyG;
    logic [NREQ-1:0] expReady;
    int              acc, nOwner, nGrant, nPtr, nCnt, idx;
    bit              nTxV;
    logic [7:0]      nTxB;
    logic [7:0]      sbExp;
    #1;
    readyG   = (mOwner >= 0) && (!mTxValid || tx_ready);
    expReady = '0;
    if (readyG) expReady[mOwner] = 1'b1;
    checkOutput("req_ready", req_ready, expReady);
    checkOutput("tx_valid", tx_valid, mTxValid);
    checkOutput("tx_byte", tx_byte, mTxByte);
    checkOutput("grant_id", grant_id, mGrant);
    checkOutput("busy", busy, (mOwner >= 0) || mTxValid);
    if (tx_valid && tx_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_empty", 32'd0, 32'd1);
      end else begin
        sbExp = sbQ.pop_front();
        checkOutput("sb_order", tx_byte, sbExp);
      end
      xferLog.push_back(tx_byte);
      xferCyc.push_back(cycCount);
    end
    acc = -1; nOwner = mOwner; nGrant = mGrant; nPtr = mPtr; nCnt = mCnt;
    nTxV = mTxValid; nTxB = mTxByte;
    if (mOwner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mPtr + k) % NREQ;
        if (nOwner < 0 && req_valid[idx]) begin
          nOwner = idx; nGrant = idx; nCnt = 0;
        end
      end
    end else if (readyG && req_valid[mOwner]) begin
      acc  = mOwner;
      nCnt = mCnt + 1;
      if (req_last[mOwner] || nCnt == MAXB) begin
        nOwner = -1;
        nCnt   = 0;
        nPtr   = (mOwner + 1) % NREQ;
      end
    end
    if (acc >= 0) begin
      nTxV = 1'b1;
      nTxB = req_byte[acc*8 +: 8];
      sbQ.push_back(nTxB);
    end else if (mTxValid && tx_ready) begin
      nTxV = 1'b0;
    end
    @(posedge clock);
    mOwner = nOwner; mGrant = nGrant; mPtr = nPtr; mCnt = nCnt;
    mTxValid = nTxV; mTxByte = nTxB;
    cycCount++;
    @(negedge clock);
    if (acc >= 0) begin
      void'(pktByte[acc].pop_front());
      void'(pktLast[acc].pop_front());
      req_valid[acc] = 1'b0;
    end
  endtask

  task automatic runCycles(input int n, input int pct);
    for (int c = 0; c < n; c++) begin
      applyStimulus(pct);
      cycle();
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_tx_valid", tx_valid, 32'd0);
    checkOutput("rst_tx_byte", tx_byte, 32'd0);
    checkOutput("rst_req_ready", req_ready, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_grant_id", grant_id, 32'd0);
    modelReset();
    clearStimulus();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_len"}, xferLog.size(), expLog.size());
    for (int i = 0; i < expLog.size(); i++) begin
      if (i < xferLog.size()) checkOutput(tag, xferLog[i], expLog[i]);
    end
  endtask

  initial begin
    bit found;
    modelReset();

    // Single requester: two-byte packet from requester 2.
    applyReset();
    tx_ready = 1'b1;
    pushByte(2, 8'hA5, 1'b0);
    pushByte(2, 8'h5A, 1'b1);
    runCycles(1, 100);
    checkOutput("single_grant", grant_id, 32'd2);
    checkOutput("single_ready", req_ready, 32'h4);
    runCycles(6, 100);
    expLog = '{8'hA5, 8'h5A};
    compareLog("single_bytes");
    if (xferCyc.size() == 2) checkOutput("single_gap", xferCyc[1] - xferCyc[0], 32'd1);
    else checkOutput("single_xfers", xferCyc.size(), 32'd2);
    xferLog.delete(); xferCyc.delete();
    pushByte(0, 8'h70, 1'b1);
    pushByte(3, 8'h73, 1'b1);
    runCycles(8, 100);
    expLog = '{8'h73, 8'h70};
    compareLog("single_rrptr");

    // Round-robin over four single-byte packets.
    applyReset();
    tx_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) pushByte(i, 8'h10 + 8'(i), 1'b1);
    pushByte(0, 8'h10, 1'b1);
    runCycles(16, 100);
    expLog = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    compareLog("rr_order");
    if (xferCyc.size() == 5) begin
      for (int k = 1; k < 5; k++) checkOutput("rr_gap", xferCyc[k] - xferCyc[k-1], 32'd2);
    end else begin
      checkOutput("rr_xfers", xferCyc.size(), 32'd5);
    end

    // Burst limit: requester 1 streams 12 bytes, requester 3 waits for its turn.
    applyReset();
    tx_ready = 1'b1;
    for (int b = 0; b < 12; b++) pushByte(1, 8'(b), (b == 11));
    pushByte(3, 8'hC3, 1'b1);
    runCycles(30, 100);
    expLog = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
               8'hC3, 8'h08, 8'h09, 8'h0A, 8'h0B};
    compareLog("burst_order");

    // Last byte coinciding with the burst limit releases only once.
    applyReset();
    tx_ready = 1'b1;
    for (int b = 0; b < MAXB; b++) pushByte(0, 8'h20 + 8'(b), (b == MAXB - 1));
    pushByte(0, 8'h28, 1'b1);
    pushByte(1, 8'h31, 1'b1);
    pushByte(2, 8'h32, 1'b1);
    runCycles(30, 100);
    expLog = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
               8'h31, 8'h32, 8'h28};
    compareLog("lastlimit_order");

    // Backpressure: transmitter stalls for five cycles after the first byte.
    applyReset();
    tx_ready = 1'b1;
    pushByte(0, 8'h3C, 1'b0);
    pushByte(0, 8'h3D, 1'b1);
    runCycles(2, 100);
    for (int k = 0; k < 5; k++) begin
      tx_ready = 1'b0;
      applyStimulus(100);
      cycle();
      checkOutput("bp_valid", tx_valid, 32'd1);
      checkOutput("bp_byte", tx_byte, 32'h3C);
      checkOutput("bp_ready", req_ready, 32'd0);
    end
    tx_ready = 1'b1;
    applyStimulus(100);
    #1;
    checkOutput("bp_release_ready", req_ready, 32'h1);
    cycle();
    checkOutput("bp_reload_valid", tx_valid, 32'd1);
    checkOutput("bp_reload_byte", tx_byte, 32'h3D);
    runCycles(3, 100);
    expLog = '{8'h3C, 8'h3D};
    compareLog("bp_bytes");

    // Reset asserted mid-packet while the output register is full.
    applyReset();
    tx_ready = 1'b1;
    for (int b = 0; b < 10; b++) pushByte(2, 8'h50 + 8'(b), (b == 9));
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      applyStimulus(100);
      cycle();
      if (mTxValid && mOwner >= 0) found = 1'b1;
    end
    checkOutput("mid_reach", found, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("mid_tx_valid", tx_valid, 32'd0);
    checkOutput("mid_req_ready", req_ready, 32'd0);
    checkOutput("mid_busy", busy, 32'd0);
    modelReset();
    clearStimulus();
    @(negedge clock);
    pushByte(1, 8'h41, 1'b1);
    pushByte(3, 8'h43, 1'b1);
    applyStimulus(100);
    reset_n = 1'b1;
    cycle();
    checkOutput("mid_first_grant", grant_id, 32'd1);
    runCycles(6, 100);
    expLog = '{8'h41, 8'h43};
    compareLog("mid_bytes");

    // Randomized traffic with random transmitter backpressure.
    applyReset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pktByte[i].size() == 0 && $urandom_range(3) == 0) genPacket(i);
      end
      tx_ready = ($urandom_range(3) != 0);
      applyStimulus(60);
      cycle();
    end
    tx_ready = 1'b1;
    runCycles(300, 100);
    checkOutput("drain_sb", sbQ.size(), 32'd0);
    checkOutput("drain_tx_valid", tx_valid, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
